// File: rtl/rv32_bus_arbiter.sv
// Purpose: arbitrates one shared RV32 memory bus between an instruction-fetch port and a data port.
// Latency: bus strobes rise the cycle after a request is seen in IDLE; ready/fault/value return combinationally in the completion cycle.
// Backpressure: requesters hold their request until ready; the bus stalls by withholding bus_ready_in, bounded by TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   instr_*                    fetch request in; read value / ready pulse / fault out
//   data_*                     read/write request with byte mask in; read value / ready pulse / fault out
//   bus_*                      shared bus strobes, address, mask, write value out; read value, ready, fault in
//   grant_data_out             high while the data port owns the bus
//
// Parameter TIMEOUT_CYCLES: number of bus cycles a transaction may wait for bus_ready_in
// before it is completed with a forced fault; 0 disables the limit.

module rv32_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,

    // instruction fetch port
    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    output logic        instr_fault_out,

    // data load/store port
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic        data_fault_out,

    // shared bus
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_address_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    input  logic        bus_fault_in,

    output logic        grant_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    // The counter only ever needs to reach TIMEOUT_CYCLES-1: the Nth bus cycle
    // is the one in which it holds N-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: data port was granted last
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // transaction fields captured on the grant edge
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wval_q, wval_d;

    logic        data_req;
    logic        pick_data;
    logic        timeout_hit;
    logic        done;
    logic        done_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            mask_q      <= 4'b0000;
            addr_q      <= 32'h0;
            wval_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            wval_q      <= wval_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        wval_d      = wval_q;

        bus_read_out         = 1'b0;
        bus_write_out        = 1'b0;
        bus_write_mask_out   = 4'b0000;
        bus_address_out      = 32'h0;
        bus_write_value_out  = 32'h0;
        instr_read_value_out = 32'h0;
        instr_ready_out      = 1'b0;
        instr_fault_out      = 1'b0;
        data_read_value_out  = 32'h0;
        data_ready_out       = 1'b0;
        data_fault_out       = 1'b0;
        grant_data_out       = 1'b0;

        data_req    = data_read_in | data_write_in;
        // On contention the port that did not win last time gets the bus.
        pick_data   = data_req & (~instr_read_in | ~last_data_q);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
        // A real bus response beats a coinciding timeout.
        done        = bus_ready_in | timeout_hit;
        done_fault  = bus_ready_in ? bus_fault_in : 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick_data) begin
                    state_d     = ST_DATA;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                    addr_d      = data_address_in;
                    // read+write together is treated as a store
                    wr_d        = data_write_in;
                    rd_d        = data_read_in & ~data_write_in;
                    mask_d      = data_write_mask_in;
                    wval_d      = data_write_value_in;
                end else if (instr_read_in) begin
                    state_d     = ST_INSTR;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                    addr_d      = instr_address_in;
                    wr_d        = 1'b0;
                    rd_d        = 1'b1;
                    mask_d      = 4'b0000;
                    wval_d      = 32'h0;
                end
            end

            ST_INSTR, ST_DATA: begin
                bus_read_out        = rd_q;
                bus_write_out       = wr_q;
                bus_write_mask_out  = mask_q;
                bus_address_out     = addr_q;
                bus_write_value_out = wval_q;
                grant_data_out      = (state_q == ST_DATA);

                if (done) begin
                    // Always drop back to IDLE so the other port gets a look-in.
                    state_d = ST_IDLE;
                    if (state_q == ST_DATA) begin
                        data_ready_out      = 1'b1;
                        data_fault_out      = done_fault;
                        data_read_value_out = bus_read_value_in;
                    end else begin
                        instr_ready_out      = 1'b1;
                        instr_fault_out      = done_fault;
                        instr_read_value_out = bus_read_value_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Purpose: self-checking bench for rv32_bus_arbiter (vector table, corner sequences, random vs model).
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: bus_ready_in is driven by the bench; every wait is a bounded cycle loop.

module tb_rv32_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic        instr_fault_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_address_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;
    logic        data_fault_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_address_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;
    logic        bus_fault_in;
    logic        grant_data_out;

    rv32_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_ready_out      (instr_ready_out),
        .instr_fault_out      (instr_fault_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_address_in      (data_address_in),
        .data_write_value_in  (data_write_value_in),
        .data_read_value_out  (data_read_value_out),
        .data_ready_out       (data_ready_out),
        .data_fault_out       (data_fault_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_address_out      (bus_address_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in),
        .bus_fault_in         (bus_fault_in),
        .grant_data_out       (grant_data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ird;
        logic [31:0] iaddr;
        logic        drd;
        logic        dwr;
        logic [3:0]  dmask;
        logic [31:0] daddr;
        logic [31:0] dwval;
        logic        brdy;
        logic        bflt;
        logic [31:0] brval;
        logic        e_brd;
        logic        e_bwr;
        logic [3:0]  e_mask;
        logic [31:0] e_addr;
        logic [31:0] e_wval;
        logic        e_gd;
        logic        e_irdy;
        logic        e_ifl;
        logic        e_drdy;
        logic        e_dfl;
        logic [31:0] e_irval;
        logic [31:0] e_drval;
    } vec_t;

    vec_t vecs [12];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        instr_read_in       = 1'b0;
        instr_address_in    = 32'h0;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_write_mask_in  = 4'h0;
        data_address_in     = 32'h0;
        data_write_value_in = 32'h0;
        bus_read_value_in   = 32'h0;
        bus_ready_in        = 1'b0;
        bus_fault_in        = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1 ({tag, "_bus_read"},  bus_read_out,  1'b0);
        chk1 ({tag, "_bus_write"}, bus_write_out, 1'b0);
        chk32({tag, "_bus_mask"},  {28'h0, bus_write_mask_out}, 32'h0);
        chk32({tag, "_bus_addr"},  bus_address_out, 32'h0);
        chk32({tag, "_bus_wval"},  bus_write_value_out, 32'h0);
        chk1 ({tag, "_grant_d"},   grant_data_out, 1'b0);
        chk1 ({tag, "_i_ready"},   instr_ready_out, 1'b0);
        chk1 ({tag, "_i_fault"},   instr_fault_out, 1'b0);
        chk32({tag, "_i_rval"},    instr_read_value_out, 32'h0);
        chk1 ({tag, "_d_ready"},   data_ready_out, 1'b0);
        chk1 ({tag, "_d_fault"},   data_fault_out, 1'b0);
        chk32({tag, "_d_rval"},    data_read_value_out, 32'h0);
    endtask

    // Reset with a live-looking bus response to show it cannot leak a pulse;
    // returns one time unit after a rising edge with reset just released.
    task automatic do_reset();
        clear_inputs();
        instr_read_in     = 1'b1;
        data_write_in     = 1'b1;
        bus_ready_in      = 1'b1;
        bus_fault_in      = 1'b1;
        bus_read_value_in = 32'hFFFF_FFFF;
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic run_vectors();
        vecs[0]  = '{default: '0, ird: 1'b1, iaddr: 32'h100, dwr: 1'b1, dmask: 4'h3,
                     daddr: 32'h200, dwval: 32'hDEADBEEF};
        vecs[1]  = '{default: '0, ird: 1'b1, iaddr: 32'h100, dwr: 1'b1, dmask: 4'h3,
                     daddr: 32'h200, dwval: 32'hDEADBEEF, brdy: 1'b1, brval: 32'hAA,
                     e_bwr: 1'b1, e_mask: 4'h3, e_addr: 32'h200, e_wval: 32'hDEADBEEF,
                     e_gd: 1'b1, e_drdy: 1'b1, e_drval: 32'hAA};
        vecs[2]  = '{default: '0, ird: 1'b1, iaddr: 32'h100};
        vecs[3]  = '{default: '0, ird: 1'b1, iaddr: 32'h100, brdy: 1'b1, brval: 32'h13,
                     e_brd: 1'b1, e_addr: 32'h100, e_irdy: 1'b1, e_irval: 32'h13};
        vecs[4]  = '{default: '0};
        vecs[5]  = '{default: '0, ird: 1'b1, iaddr: 32'h100};
        vecs[6]  = '{default: '0, ird: 1'b1, iaddr: 32'h100, brval: 32'h77,
                     e_brd: 1'b1, e_addr: 32'h100};
        vecs[7]  = '{default: '0, ird: 1'b1, iaddr: 32'h100, brdy: 1'b1, brval: 32'h13,
                     e_brd: 1'b1, e_addr: 32'h100, e_irdy: 1'b1, e_irval: 32'h13};
        vecs[8]  = '{default: '0};
        vecs[9]  = '{default: '0, drd: 1'b1, dwr: 1'b1, dmask: 4'hF, daddr: 32'h300,
                     dwval: 32'h12345678};
        vecs[10] = '{default: '0, drd: 1'b1, dwr: 1'b1, dmask: 4'hF, daddr: 32'h300,
                     dwval: 32'h12345678, brdy: 1'b1, bflt: 1'b1,
                     e_bwr: 1'b1, e_mask: 4'hF, e_addr: 32'h300, e_wval: 32'h12345678,
                     e_gd: 1'b1, e_drdy: 1'b1, e_dfl: 1'b1};
        vecs[11] = '{default: '0};

        for (int i = 0; i < 12; i++) begin
            instr_read_in       = vecs[i].ird;
            instr_address_in    = vecs[i].iaddr;
            data_read_in        = vecs[i].drd;
            data_write_in       = vecs[i].dwr;
            data_write_mask_in  = vecs[i].dmask;
            data_address_in     = vecs[i].daddr;
            data_write_value_in = vecs[i].dwval;
            bus_ready_in        = vecs[i].brdy;
            bus_fault_in        = vecs[i].bflt;
            bus_read_value_in   = vecs[i].brval;
            @(negedge clk);
            chk1 ($sformatf("v%0d_bus_read", i),  bus_read_out,  vecs[i].e_brd);
            chk1 ($sformatf("v%0d_bus_write", i), bus_write_out, vecs[i].e_bwr);
            chk32($sformatf("v%0d_bus_mask", i),  {28'h0, bus_write_mask_out}, {28'h0, vecs[i].e_mask});
            chk32($sformatf("v%0d_bus_addr", i),  bus_address_out, vecs[i].e_addr);
            chk32($sformatf("v%0d_bus_wval", i),  bus_write_value_out, vecs[i].e_wval);
            chk1 ($sformatf("v%0d_grant_d", i),   grant_data_out, vecs[i].e_gd);
            chk1 ($sformatf("v%0d_i_ready", i),   instr_ready_out, vecs[i].e_irdy);
            chk1 ($sformatf("v%0d_i_fault", i),   instr_fault_out, vecs[i].e_ifl);
            chk32($sformatf("v%0d_i_rval", i),    instr_read_value_out, vecs[i].e_irval);
            chk1 ($sformatf("v%0d_d_ready", i),   data_ready_out, vecs[i].e_drdy);
            chk1 ($sformatf("v%0d_d_fault", i),   data_fault_out, vecs[i].e_dfl);
            chk32($sformatf("v%0d_d_rval", i),    data_read_value_out, vecs[i].e_drval);
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Both ports request continuously; grants must alternate starting with data.
    task automatic alt_test();
        string seq;
        int    n;
        int    b2b;
        logic  prev;
        logic  cur;
        seq  = "";
        n    = 0;
        b2b  = 0;
        prev = 1'b0;
        do_reset();
        instr_read_in       = 1'b1;
        instr_address_in    = 32'h100;
        data_write_in       = 1'b1;
        data_write_mask_in  = 4'hF;
        data_address_in     = 32'h200;
        data_write_value_in = 32'h1;
        bus_ready_in        = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            cur = data_ready_out | instr_ready_out;
            if (data_ready_out)  seq = {seq, "D"};
            if (instr_ready_out) seq = {seq, "I"};
            if (cur && prev) b2b++;
            if (cur) n++;
            prev = cur;
            @(posedge clk);
            #1;
        end
        chk32("alt_count", n, 32'd4);
        chk32("alt_back_to_back", b2b, 32'd0);
        checks++;
        if (seq != "DIDI") begin
            failures++;
            $display("FAIL alt_order: got %s expected DIDI", seq);
        end
        clear_inputs();
    endtask

    // Data read that waits for the timeout; rdy4/flt4 drive the bus in the last allowed cycle.
    task automatic timeout_run(input logic rdy4, input logic flt4, input string tag);
        logic exp_f;
        exp_f = rdy4 ? flt4 : 1'b1;
        do_reset();
        data_read_in    = 1'b1;
        data_address_in = 32'h400;
        @(negedge clk);
        chk1({tag, "_c0_bus_read"}, bus_read_out, 1'b0);
        for (int n = 1; n <= TO; n++) begin
            @(posedge clk);
            #1;
            if (n == TO) begin
                bus_ready_in      = rdy4;
                bus_fault_in      = flt4;
                bus_read_value_in = 32'h5A5A0000;
            end
            @(negedge clk);
            chk1($sformatf("%s_c%0d_bus_read", tag, n), bus_read_out, 1'b1);
            chk1($sformatf("%s_c%0d_d_ready", tag, n), data_ready_out, n == TO);
            chk1($sformatf("%s_c%0d_d_fault", tag, n), data_fault_out, (n == TO) ? exp_f : 1'b0);
            if (n == TO)
                chk32($sformatf("%s_c%0d_d_rval", tag, n), data_read_value_out, 32'h5A5A0000);
        end
        @(posedge clk);
        #1;
        data_read_in = 1'b0;
        @(negedge clk);
        chk1({tag, "_idle_bus_read"}, bus_read_out, 1'b0);
        chk1({tag, "_idle_grant_d"},  grant_data_out, 1'b0);
        chk1({tag, "_idle_d_ready"},  data_ready_out, 1'b0);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Reset lands in the second bus cycle of a store.
    task automatic mid_reset_test();
        do_reset();
        data_write_in       = 1'b1;
        data_write_mask_in  = 4'h3;
        data_address_in     = 32'h500;
        data_write_value_in = 32'hCAFE0000;
        @(negedge clk);
        chk1("mr_c0_bus_write", bus_write_out, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("mr_c1_bus_write", bus_write_out, 1'b1);
        chk32("mr_c1_bus_addr", bus_address_out, 32'h500);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        bus_ready_in = 1'b1;
        #1;
        chk_all_zero("mr_abort");
        @(negedge clk);
        chk_all_zero("mr_hold");
        @(posedge clk);
        #1;
        clear_inputs();
        reset            = 1'b1;
        instr_read_in    = 1'b1;
        instr_address_in = 32'h600;
        @(negedge clk);
        chk1("mr_rel_idle_bus_read", bus_read_out, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("mr_rel_bus_read", bus_read_out, 1'b1);
        chk32("mr_rel_bus_addr", bus_address_out, 32'h600);
        chk1("mr_rel_grant_d", grant_data_out, 1'b0);
        @(posedge clk);
        #1;
        bus_ready_in      = 1'b1;
        bus_read_value_in = 32'h33;
        @(negedge clk);
        chk1("mr_rel_i_ready", instr_ready_out, 1'b1);
        chk32("mr_rel_i_rval", instr_read_value_out, 32'h33);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Random requesters against a transaction-level reference.
    task automatic rand_run(input int ncycles);
        logic        i_pend, d_pend, d_rd, d_wr;
        logic        seen_ir, seen_dr;
        // reference: the transaction currently owning the bus, if any
        logic        busy;
        logic        own_d;
        logic        t_rd, t_wr;
        logic [3:0]  t_mask;
        logic [31:0] t_addr, t_wval;
        int          elapsed;
        logic        last_was_d;
        logic        fin, flt, dq, iq, take_d;
        i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0;
        seen_ir = 0; seen_dr = 0;
        busy = 0; own_d = 0; t_rd = 0; t_wr = 0; t_mask = 0; t_addr = 0; t_wval = 0;
        elapsed = 0; last_was_d = 0;
        do_reset();
        for (int c = 0; c < ncycles; c++) begin
            if (seen_ir) i_pend = 1'b0;
            if (seen_dr) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                instr_address_in = $urandom;
            end else if (i_pend && $urandom_range(0, 15) == 0) begin
                i_pend = 1'b0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                case ($urandom_range(0, 2))
                    0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                    1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                    default: begin d_rd = 1'b1; d_wr = 1'b1; end
                endcase
                data_address_in     = $urandom;
                data_write_value_in = $urandom;
                data_write_mask_in  = 4'($urandom_range(0, 15));
            end else if (d_pend && $urandom_range(0, 15) == 0) begin
                d_pend = 1'b0;
            end
            instr_read_in     = i_pend;
            data_read_in      = d_pend & d_rd;
            data_write_in     = d_pend & d_wr;
            bus_ready_in      = ($urandom_range(0, 2) == 0);
            bus_fault_in      = ($urandom_range(0, 3) == 0);
            bus_read_value_in = $urandom;

            @(negedge clk);
            seen_ir = 1'b0;
            seen_dr = 1'b0;
            fin     = 1'b0;
            flt     = 1'b0;
            if (busy) begin
                fin = bus_ready_in || (TO != 0 && elapsed + 1 == TO);
                flt = bus_ready_in ? bus_fault_in : 1'b1;
                seen_ir = fin && !own_d;
                seen_dr = fin && own_d;
            end
            chk1 ($sformatf("rnd%0d_bus_read", c),  bus_read_out,  busy && t_rd);
            chk1 ($sformatf("rnd%0d_bus_write", c), bus_write_out, busy && t_wr);
            chk32($sformatf("rnd%0d_bus_mask", c),  {28'h0, bus_write_mask_out}, busy ? {28'h0, t_mask} : 32'h0);
            chk32($sformatf("rnd%0d_bus_addr", c),  bus_address_out, busy ? t_addr : 32'h0);
            chk32($sformatf("rnd%0d_bus_wval", c),  bus_write_value_out, busy ? t_wval : 32'h0);
            chk1 ($sformatf("rnd%0d_grant_d", c),   grant_data_out, busy && own_d);
            chk1 ($sformatf("rnd%0d_i_ready", c),   instr_ready_out, seen_ir);
            chk1 ($sformatf("rnd%0d_i_fault", c),   instr_fault_out, seen_ir && flt);
            chk32($sformatf("rnd%0d_i_rval", c),    instr_read_value_out, seen_ir ? bus_read_value_in : 32'h0);
            chk1 ($sformatf("rnd%0d_d_ready", c),   data_ready_out, seen_dr);
            chk1 ($sformatf("rnd%0d_d_fault", c),   data_fault_out, seen_dr && flt);
            chk32($sformatf("rnd%0d_d_rval", c),    data_read_value_out, seen_dr ? bus_read_value_in : 32'h0);

            // advance the reference across the coming rising edge
            if (busy) begin
                if (fin) busy = 1'b0;
                else     elapsed++;
            end else begin
                dq = data_read_in | data_write_in;
                iq = instr_read_in;
                take_d = (dq && iq) ? !last_was_d : dq;
                if (dq || iq) begin
                    busy       = 1'b1;
                    own_d      = take_d;
                    last_was_d = take_d;
                    elapsed    = 0;
                    if (take_d) begin
                        t_wr   = data_write_in;
                        t_rd   = !data_write_in;
                        t_mask = data_write_mask_in;
                        t_addr = data_address_in;
                        t_wval = data_write_value_in;
                    end else begin
                        t_wr   = 1'b0;
                        t_rd   = 1'b1;
                        t_mask = 4'h0;
                        t_addr = instr_address_in;
                        t_wval = 32'h0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        do_reset();
        run_vectors();
        alt_test();
        timeout_run(1'b0, 1'b0, "to");
        timeout_run(1'b1, 1'b1, "tie_f1");
        timeout_run(1'b1, 1'b0, "tie_f0");
        mid_reset_test();
        rand_run(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
